// File: rtl/regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_access_ctrl
//
// Sequencer placed directly in front of the 32x16 register file. It accepts
// one access request at a time, pulses the register file's valid lines for a
// single cycle, holds addresses and write data stable while the register
// file's 2-cycle internal delay runs, captures the read ports on the correct
// edge and returns the result on a valid/ready response channel. Serialising
// all accesses removes read-after-write and re-trigger hazards for requesters.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   req_valid / req_ready            request handshake
//   req_rd1, req_rd2, req_wr         read port 1 / read port 2 / write enables
//   req_raddr1, req_raddr2           read addresses
//   req_waddr, req_wdata             write address and data
//   resp_valid / resp_ready          response handshake
//   resp_rdata1, resp_rdata2         read results (0 for a disabled port)
//   rf_valid[2:0]                    to register file: {wr, rd2, rd1}
//   rf_read_addr_1/2, rf_write_addr  to register file
//   rf_write_data                    to register file
//   rf_read_1, rf_read_2             from register file
//
// Every output is a register: there is no combinational path from req_* or
// resp_ready to any output.
// -----------------------------------------------------------------------------
module regfile_access_ctrl #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rd1,
  input  logic              req_rd2,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_raddr1,
  input  logic [ADDR_W-1:0] req_raddr2,
  input  logic [ADDR_W-1:0] req_waddr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata1,
  output logic [DATA_W-1:0] resp_rdata2,
  output logic [2:0]        rf_valid,
  output logic [ADDR_W-1:0] rf_read_addr_1,
  output logic [ADDR_W-1:0] rf_read_addr_2,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_1,
  input  logic [DATA_W-1:0] rf_read_2
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    ISSUE,
    WAIT1,
    WAIT2,
    CAPT,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;
  // Read enables of the accepted request, kept for the capture cycle.
  logic             rd1_en;
  logic             rd2_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= DRAIN;
      drain_cnt      <= CNT_W'(DRAIN_CYCLES);
      rd1_en         <= 1'b0;
      rd2_en         <= 1'b0;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata1    <= '0;
      resp_rdata2    <= '0;
      rf_valid       <= 3'b000;
      rf_read_addr_1 <= '0;
      rf_read_addr_2 <= '0;
      rf_write_addr  <= '0;
      rf_write_data  <= '0;
    end else begin
      // rf_valid is a single-cycle pulse: re-asserting it would restart the
      // register file's internal delay counter.
      rf_valid <= 3'b000;

      case (state)
        // Wait for any access that was in flight at reset to complete. Its
        // addresses/data are now zero, so a pending write lands in scratch
        // register 0.
        DRAIN: begin
          if (drain_cnt <= CNT_W'(1)) begin
            drain_cnt <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end

        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready      <= 1'b0;
            // Addresses and write data stay put until the next acceptance.
            rf_read_addr_1 <= req_raddr1;
            rf_read_addr_2 <= req_raddr2;
            rf_write_addr  <= req_waddr;
            rf_write_data  <= req_wdata;
            rd1_en         <= req_rd1;
            rd2_en         <= req_rd2;
            if (req_rd1 || req_rd2 || req_wr) begin
              rf_valid <= {req_wr, req_rd2, req_rd1};
              state    <= ISSUE;
            end else begin
              // Null request: answer immediately with zero data.
              resp_rdata1 <= '0;
              resp_rdata2 <= '0;
              resp_valid  <= 1'b1;
              state       <= RESP;
            end
          end
        end

        ISSUE: state <= WAIT1;
        WAIT1: state <= WAIT2;
        WAIT2: state <= CAPT;

        // Register file read ports were updated on the previous edge.
        CAPT: begin
          resp_rdata1 <= rd1_en ? rf_read_1 : '0;
          resp_rdata2 <= rd2_en ? rf_read_2 : '0;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          req_ready  <= 1'b0;
          resp_valid <= 1'b0;
          drain_cnt  <= CNT_W'(DRAIN_CYCLES);
          state      <= DRAIN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_access_ctrl. Contains a behavioural model of the
// 32x16 register file (valid seen on one edge, reads/write committed two
// edges later, re-assertion restarts the delay) and a golden memory that
// produces expected responses, which are queued at request time and compared
// when the response appears.
// -----------------------------------------------------------------------------
module tb_regfile_access_ctrl;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rd1 = 1'b0;
  logic          req_rd2 = 1'b0;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_raddr1 = '0;
  logic [AW-1:0] req_raddr2 = '0;
  logic [AW-1:0] req_waddr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_rdata1;
  logic [DW-1:0] resp_rdata2;
  logic [2:0]    rf_valid;
  logic [AW-1:0] rf_read_addr_1;
  logic [AW-1:0] rf_read_addr_2;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_write_data;
  logic [DW-1:0] rf_read_1 = '0;
  logic [DW-1:0] rf_read_2 = '0;

  always #5 clk = ~clk;

  regfile_access_ctrl #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd1(req_rd1),
    .req_rd2(req_rd2),
    .req_wr(req_wr),
    .req_raddr1(req_raddr1),
    .req_raddr2(req_raddr2),
    .req_waddr(req_waddr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata1(resp_rdata1),
    .resp_rdata2(resp_rdata2),
    .rf_valid(rf_valid),
    .rf_read_addr_1(rf_read_addr_1),
    .rf_read_addr_2(rf_read_addr_2),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .rf_read_1(rf_read_1),
    .rf_read_2(rf_read_2)
  );

  // Register file model: not reset, so an access in flight at reset completes.
  logic [DW-1:0] rf_mem [32] = '{default: 16'h0000};
  logic [1:0]    rf_cnt = 2'd0;
  logic [2:0]    rf_pend = 3'b000;

  always @(posedge clk) begin
    if (rf_valid != 3'b000) begin
      rf_cnt  <= 2'd2;
      rf_pend <= rf_valid;
    end else if (rf_cnt == 2'd2) begin
      rf_cnt <= 2'd1;
    end else if (rf_cnt == 2'd1) begin
      rf_cnt <= 2'd0;
      if (rf_pend[0]) rf_read_1 <= rf_mem[rf_read_addr_1];
      if (rf_pend[1]) rf_read_2 <= rf_mem[rf_read_addr_2];
      if (rf_pend[2]) rf_mem[rf_write_addr] <= rf_write_data;
    end
  end

  // Scoreboard state
  int            tests_run = 0;
  int            tests_failed = 0;
  logic [31:0]   exp_q [$];
  logic [DW-1:0] ref_mem [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete request/response transaction. stall > 0 holds resp_ready low
  // for that many cycles while an intruding request is presented.
  task automatic do_req(input logic r1, input logic r2, input logic w,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] aw, input logic [DW-1:0] wd,
                        input bit chk_lat, input int stall);
    int            n;
    int            k;
    int            pulses;
    logic [2:0]    pulse_val;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic [31:0]   got;
    logic [31:0]   exp;

    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before", 32'(req_ready), 32'd1);

    req_rd1    = r1;
    req_rd2    = r2;
    req_wr     = w;
    req_raddr1 = a1;
    req_raddr2 = a2;
    req_waddr  = aw;
    req_wdata  = wd;
    req_valid  = 1'b1;
    resp_ready = (stall == 0);

    // Golden: reads see the value before this request's write.
    e1 = r1 ? ref_mem[a1] : 16'h0000;
    e2 = r2 ? ref_mem[a2] : 16'h0000;
    if (w) ref_mem[aw] = wd;
    exp_q.push_back({e1, e2});

    @(negedge clk);  // acceptance edge has passed
    req_valid = 1'b0;

    pulses    = 0;
    pulse_val = 3'b000;
    k         = 0;
    while (!resp_valid && k < 20) begin
      if (rf_valid != 3'b000) begin
        pulses++;
        pulse_val = rf_valid;
      end
      @(negedge clk);
      k++;
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    if (chk_lat) chk("latency", 32'(k), 32'd4);
    if (r1 || r2 || w) begin
      chk("rf_valid_pulses", 32'(pulses), 32'd1);
      chk("rf_valid_bits", 32'(pulse_val), 32'({w, r2, r1}));
    end

    got = {resp_rdata1, resp_rdata2};
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'(exp_q.size()), 32'd1);
      exp = 32'h0;
    end else begin
      exp = exp_q.pop_front();
    end
    chk("rdata", got, exp);

    if (stall > 0) begin
      // Intruder: a write to register 3 that must not be accepted.
      req_wr    = 1'b1;
      req_rd1   = 1'b0;
      req_rd2   = 1'b0;
      req_waddr = 5'd3;
      req_wdata = 16'hDEAD;
      req_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_resp_valid", 32'(resp_valid), 32'd1);
        chk("stall_rdata", {resp_rdata1, resp_rdata2}, exp);
        chk("stall_req_ready", 32'(req_ready), 32'd0);
        chk("stall_rf_valid", 32'(rf_valid), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end

    @(negedge clk);  // handshake edge has passed
    chk("resp_valid_after_hs", 32'(resp_valid), 32'd0);
    chk("req_ready_after_hs", 32'(req_ready), 32'd1);

    $display("[TB] txn rd1=%0b rd2=%0b wr=%0b a1=%0d a2=%0d aw=%0d wd=%h -> rdata %h/%h lat=%0d",
             r1, r2, w, a1, a2, aw, wd, got[31:16], got[15:0], k);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_rf_valid"}, 32'(rf_valid), 32'd0);
    chk({tag, "_rf_addrs"}, 32'({rf_read_addr_1, rf_read_addr_2, rf_write_addr}), 32'd0);
    chk({tag, "_rf_wdata"}, 32'(rf_write_data), 32'd0);
    chk({tag, "_rdata"}, {resp_rdata1, resp_rdata2}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) ref_mem[i] = 16'h0000;

    // Power-on reset and drain length
    repeat (3) @(negedge clk);
    chk_all_zero("por");
    rst_n = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("drain_cycles", 32'(n), 32'd3);
    $display("[TB] txn reset release, req_ready after %0d cycles", n);

    // Write then read back
    do_req(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 16'hBEEF, 1'b1, 0);
    do_req(1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 16'h0000, 1'b1, 0);
    // Dual read
    do_req(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 16'h0000, 1'b1, 0);
    // Combined read+write same address returns old value
    do_req(1'b1, 1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 16'h1234, 1'b1, 0);
    // Read back with 10-cycle response back-pressure
    do_req(1'b1, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 16'h0000, 1'b1, 10);
    // Register 3 must not have been written by the intruder
    do_req(1'b0, 1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 16'h0000, 1'b1, 0);
    // Null request
    do_req(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 16'h7777, 1'b0, 0);
    // Put a visible value in scratch register 0
    do_req(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 16'h5555, 1'b1, 0);
    do_req(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1, 0);

    // Reset during WAIT1 of a write to register 9
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    req_rd1   = 1'b0;
    req_rd2   = 1'b0;
    req_wr    = 1'b1;
    req_waddr = 5'd9;
    req_wdata = 16'hAAAA;
    req_valid = 1'b1;
    @(negedge clk);  // accepted, ISSUE
    req_valid = 1'b0;
    @(negedge clk);  // WAIT1
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);  // in-flight write has committed with zeroed addr/data
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    ref_mem[0] = 16'h0000;
    rst_n = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin
      chk("drain_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("drain_cycles_midrst", 32'(n), 32'd3);
    $display("[TB] txn mid-op reset, req_ready after %0d cycles", n);
    do_req(1'b1, 1'b1, 1'b0, 5'd0, 5'd9, 5'd0, 16'h0000, 1'b1, 0);

    // Random traffic
    for (int t = 0; t < 8; t++) begin
      logic r1, r2, w;
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      do_req(r1, r2, w, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 16'($urandom), (r1 | r2 | w), 0);
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
